alu_datapath: RTL and testbench

ALU_DATAPATH -- requirements
Module: alu_datapath

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_iter_unit.sv | 105 ++++++++++
 rtl/alu_datapath.sv | 180 ++++++++++++++++++
 tb/tb_alu_datapath.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the ALU datapath and its controller.
//   Opcode encodings, FSM state type, flag bit positions, default operand
//   width and the op-strobe priority encoder.
package alu_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [3:0] {
    OP_NONE = 4'h0,
    OP_CMP  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_DIV  = 4'h4,
    OP_MUL  = 4'h5
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } alu_state_e;

  // flags = {err, carry, lt, eq, gt}
  localparam int FLAG_GT    = 0;
  localparam int FLAG_EQ    = 1;
  localparam int FLAG_LT    = 2;
  localparam int FLAG_CARRY = 3;
  localparam int FLAG_ERR   = 4;
  localparam int FLAG_W     = 5;

  // Cmp > Add > Sub > Div > Mul; the losers are simply dropped.
  function automatic alu_op_e pick_op(input logic cmp, input logic add,
                                      input logic sub, input logic div,
                                      input logic mul);
    alu_op_e op;
    op = OP_NONE;
    if (cmp)      op = OP_CMP;
    else if (add) op = OP_ADD;
    else if (sub) op = OP_SUB;
    else if (div) op = OP_DIV;
    else if (mul) op = OP_MUL;
    return op;
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// alu_iter_unit -- iterative datapath for the multi-cycle ops.
//   Unsigned shift-add multiply and (with ALU_DP_DIV_EN) unsigned restoring
//   divide, one bit per cycle, sequenced by a down-counter loaded with WIDTH.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   start_i      load operands and start an iteration run
//   div_i        (ALU_DP_DIV_EN only) start a divide instead of a multiply
//   a_i, b_i     operands (multiplicand/multiplier or dividend/divisor)
//   last_o       the step taken on the coming edge is the final one
//   result_o     value the product/{rem,quot} register takes on the coming step
module alu_iter_unit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
`ifdef ALU_DP_DIV_EN
  input  logic               div_i,
`endif
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH + 1);

  // mul: {accumulator, remaining multiplier bits}; div: {remainder, quotient}
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] step_next;
`ifdef ALU_DP_DIV_EN
  logic               div_q, div_d;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;
  logic               fits;
`endif

  always_comb begin
    mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
    step_next = {mul_sum, p_q[WIDTH-1:1]};
`ifdef ALU_DP_DIV_EN
    // rem_sh < 2*divisor, so trial's top bit is set exactly when it went negative.
    rem_sh = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, m_q};
    fits   = ~trial[WIDTH];
    if (div_q) begin
      step_next = {(fits ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                   p_q[WIDTH-2:0], fits};
    end
`endif
  end

  always_comb begin
    p_d   = p_q;
    m_d   = m_q;
    cnt_d = cnt_q;
`ifdef ALU_DP_DIV_EN
    div_d = div_q;
`endif
    if (start_i) begin
      cnt_d = CW'(WIDTH);
`ifdef ALU_DP_DIV_EN
      div_d = div_i;
      if (div_i) begin
        p_d = {{WIDTH{1'b0}}, a_i};
        m_d = b_i;
      end else begin
        p_d = {{WIDTH{1'b0}}, b_i};
        m_d = a_i;
      end
`else
      p_d = {{WIDTH{1'b0}}, b_i};
      m_d = a_i;
`endif
    end else if (cnt_q != '0) begin
      p_d   = step_next;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q   <= '0;
      m_q   <= '0;
      cnt_q <= '0;
`ifdef ALU_DP_DIV_EN
      div_q <= 1'b0;
`endif
    end else begin
      p_q   <= p_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
`ifdef ALU_DP_DIV_EN
      div_q <= div_d;
`endif
    end
  end

  assign last_o   = (cnt_q == CW'(1));
  assign result_o = step_next;

endmodule

// File: rtl/alu_datapath.sv
// alu_datapath -- operand registers, single-cycle ops and sequencing FSM.
//   CMP/ADD/SUB finish in one cycle; MUL (and DIV when ALU_DP_DIV_EN is
//   defined) run WIDTH cycles in alu_iter_unit. Without ALU_DP_DIV_EN a
//   divide request returns result=0 with err set after one cycle.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   ldA, ldB, opA_in, opB_in   operand load strobes and data (IDLE only)
//   aCmp aAdd aSub aDiv aMul   op strobes, priority Cmp>Add>Sub>Div>Mul
//   result, flags              held result and {err,carry,lt,eq,gt}
//   done                       one-cycle pulse when result/flags update
//   busy                       op in progress (RUN or DONE)
//   overrun                    pulse: a strobe arrived while busy and was dropped
//
// state  | meaning
// S_IDLE | accepting loads and op strobes
// S_RUN  | iterating MUL/DIV one bit per cycle
// S_DONE | result valid, done high; back to IDLE next edge
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ldA,
  input  logic               ldB,
  input  logic               aCmp,
  input  logic               aAdd,
  input  logic               aSub,
  input  logic               aDiv,
  input  logic               aMul,
  input  logic [WIDTH-1:0]   opA_in,
  input  logic [WIDTH-1:0]   opB_in,
  output logic [2*WIDTH-1:0] result,
  output logic [FLAG_W-1:0]  flags,
  output logic               done,
  output logic               busy,
  output logic               overrun
);

  alu_state_e         state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [FLAG_W-1:0]  flags_q, flags_d;
  logic               overrun_q, overrun_d;

  alu_op_e            op_sel;
  logic               any_req;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH-1:0]   sub_diff;
  logic               a_lt_b;

  logic               iter_start;
  logic               iter_last;
  logic [2*WIDTH-1:0] iter_result;
`ifdef ALU_DP_DIV_EN
  logic               iter_div;
`endif

  assign op_sel   = pick_op(aCmp, aAdd, aSub, aDiv, aMul);
  assign any_req  = aCmp | aAdd | aSub | aDiv | aMul | ldA | ldB;
  assign add_sum  = {1'b0, a_q} + {1'b0, b_q};
  assign sub_diff = a_q - b_q;
  assign a_lt_b   = (a_q < b_q);

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    flags_d    = flags_q;
    overrun_d  = 1'b0;
    iter_start = 1'b0;
`ifdef ALU_DP_DIV_EN
    iter_div   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        case (op_sel)
          OP_CMP: begin
            result_d         = '0;
            flags_d          = '0;
            flags_d[FLAG_LT] = a_lt_b;
            flags_d[FLAG_EQ] = (a_q == b_q);
            flags_d[FLAG_GT] = ~a_lt_b & (a_q != b_q);
            state_d          = S_DONE;
          end
          OP_ADD: begin
            result_d            = {{(WIDTH-1){1'b0}}, add_sum};
            flags_d             = '0;
            flags_d[FLAG_CARRY] = add_sum[WIDTH];
            state_d             = S_DONE;
          end
          OP_SUB: begin
            result_d            = {{WIDTH{1'b0}}, sub_diff};
            flags_d             = '0;
            flags_d[FLAG_CARRY] = a_lt_b;
            state_d             = S_DONE;
          end
          OP_DIV: begin
`ifdef ALU_DP_DIV_EN
            if (b_q == '0) begin
              // divide by zero: remainder=A, quotient saturates
              result_d          = {a_q, {WIDTH{1'b1}}};
              flags_d           = '0;
              flags_d[FLAG_ERR] = 1'b1;
              state_d           = S_DONE;
            end else begin
              iter_start = 1'b1;
              iter_div   = 1'b1;
              state_d    = S_RUN;
            end
`else
            result_d          = '0;
            flags_d           = '0;
            flags_d[FLAG_ERR] = 1'b1;
            state_d           = S_DONE;
`endif
          end
          OP_MUL: begin
            iter_start = 1'b1;
            state_d    = S_RUN;
          end
          default: ;
        endcase
      end
      S_RUN: begin
        overrun_d = any_req;
        if (iter_last) begin
          result_d = iter_result;
          flags_d  = '0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        overrun_d = any_req;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      overrun_q <= overrun_d;
      if (state_q == S_IDLE) begin
        if (ldA) a_q <= opA_in;
        if (ldB) b_q <= opB_in;
      end
    end
  end

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .reset    (reset),
    .start_i  (iter_start),
`ifdef ALU_DP_DIV_EN
    .div_i    (iter_div),
`endif
    .a_i      (a_q),
    .b_i      (b_q),
    .last_o   (iter_last),
    .result_o (iter_result)
  );

  assign result  = result_q;
  assign flags   = flags_q;
  assign done    = (state_q == S_DONE);
  assign busy    = (state_q != S_IDLE);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_alu_datapath.sv
// tb_alu_datapath -- self-checking bench for alu_datapath (WIDTH=8).
//   Expected values come from an arithmetic reference model; the divide
//   expectations follow ALU_DP_DIV_EN as the design build does.
module tb_alu_datapath;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           ldA = 1'b0, ldB = 1'b0;
  logic           aCmp = 1'b0, aAdd = 1'b0, aSub = 1'b0, aDiv = 1'b0, aMul = 1'b0;
  logic [W-1:0]   opA_in = '0, opB_in = '0;
  logic [2*W-1:0] result;
  logic [4:0]     flags;
  logic           done, busy, overrun;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;

  alu_datapath #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .ldA     (ldA),
    .ldB     (ldB),
    .aCmp    (aCmp),
    .aAdd    (aAdd),
    .aSub    (aSub),
    .aDiv    (aDiv),
    .aMul    (aMul),
    .opA_in  (opA_in),
    .opB_in  (opB_in),
    .result  (result),
    .flags   (flags),
    .done    (done),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_strb(input logic [4:0] s);
    {aCmp, aAdd, aSub, aDiv, aMul} = s;
  endtask

  // s = {cmp, add, sub, div, mul}; f = {err, carry, lt, eq, gt}
  function automatic void model(input logic [4:0] s, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [2*W-1:0] r,
                                output logic [4:0] f, output int lat);
    int ia, ib, m;
    ia = int'(a);
    ib = int'(b);
    m = 1 << W;
    r = '0;
    f = '0;
    lat = 1;
    if (s[4]) begin
      f[2] = (ia < ib);
      f[1] = (ia == ib);
      f[0] = (ia > ib);
    end else if (s[3]) begin
      r = (2*W)'(ia + ib);
      f[3] = (ia + ib) >= m;
    end else if (s[2]) begin
      r = (2*W)'((ia - ib + m) % m);
      f[3] = (ia < ib);
    end else if (s[1]) begin
`ifdef ALU_DP_DIV_EN
      if (ib == 0) begin
        r = (2*W)'(ia * m + m - 1);
        f[4] = 1'b1;
      end else begin
        r = (2*W)'((ia % ib) * m + ia / ib);
        lat = W + 1;
      end
`else
      f[4] = 1'b1;
`endif
    end else if (s[0]) begin
      r = (2*W)'(ia * ib);
      lat = W + 1;
    end
  endfunction

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
    ldA = 1'b1; ldB = 1'b1; opA_in = a; opB_in = b;
    tick();
    ldA = 1'b0; ldB = 1'b0;
    m_a = a; m_b = b;
  endtask

  // Pulse op strobes (optionally with same-edge loads), wait for done, check.
  task automatic issue(input logic [4:0] s, input logic la, input logic lb,
                       input logic [W-1:0] na, input logic [W-1:0] nb,
                       input string nm);
    logic [2*W-1:0] er;
    logic [4:0]     ef;
    int             el, cyc, bsy, ovr;
    logic           seen;
    model(s, m_a, m_b, er, ef, el);
    set_strb(s); ldA = la; ldB = lb; opA_in = na; opB_in = nb;
    tick();
    set_strb(5'b0); ldA = 1'b0; ldB = 1'b0;
    if (la) m_a = na;
    if (lb) m_b = nb;
    cyc = 1; bsy = 0; ovr = 0; seen = 1'b0;
    while (cyc <= 60) begin
      @(negedge clk);
      if (busy === 1'b1) bsy++;
      if (overrun === 1'b1) ovr++;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
      cyc++;
    end
    total++;
    if (!seen || cyc != el) begin
      bad++;
      $display("FAIL %s latency: got %0d (done seen %0b) want %0d", nm, cyc, seen, el);
    end
    total++;
    if (result !== er) begin
      bad++;
      $display("FAIL %s result: got %h want %h", nm, result, er);
    end
    total++;
    if (flags !== ef) begin
      bad++;
      $display("FAIL %s flags: got %b want %b", nm, flags, ef);
    end
    total++;
    if (bsy != el || ovr != 0) begin
      bad++;
      $display("FAIL %s busy/overrun cycles: got %0d/%0d want %0d/0", nm, bsy, ovr, el);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s after done: done=%b busy=%b want 0/0", nm, done, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_strb(5'b00001); ldA = 1'b1; opA_in = 8'h55;
    tick(); tick(); tick();
    @(negedge clk);
    total++;
    if (result !== '0 || flags !== '0 || done !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL reset outputs: result=%h flags=%b done=%b busy=%b ovr=%b want all 0",
               result, flags, done, busy, overrun);
    end
    set_strb(5'b0); ldA = 1'b0; opA_in = '0;
    tick();
    reset = 1'b0;
    m_a = '0; m_b = '0;
    tick();
    issue(5'b10000, 1'b0, 1'b0, '0, '0, "reset_cmp");
  endtask

  task automatic test_vectors();
    load(8'd200, 8'd100);
    issue(5'b01000, 1'b0, 1'b0, '0, '0, "add_200_100");
    total++;
    if (result !== 16'h012C || flags[3] !== 1'b1) begin
      bad++;
      $display("FAIL add_vec: got %h carry %b want 012c carry 1", result, flags[3]);
    end
    load(8'd5, 8'd9);
    issue(5'b00100, 1'b0, 1'b0, '0, '0, "sub_5_9");
    total++;
    if (result !== 16'h00FC || flags[3] !== 1'b1) begin
      bad++;
      $display("FAIL sub_vec: got %h carry %b want 00fc carry 1", result, flags[3]);
    end
    issue(5'b10000, 1'b0, 1'b0, '0, '0, "cmp_5_9");
    total++;
    if (flags !== 5'b00100) begin
      bad++;
      $display("FAIL cmp_vec: got %b want 00100", flags);
    end
    load(8'd255, 8'd255);
    issue(5'b00001, 1'b0, 1'b0, '0, '0, "mul_255_255");
    total++;
    if (result !== 16'hFE01) begin
      bad++;
      $display("FAIL mul_vec: got %h want fe01", result);
    end
    load(8'd100, 8'd7);
    issue(5'b00010, 1'b0, 1'b0, '0, '0, "div_100_7");
    total++;
`ifdef ALU_DP_DIV_EN
    if (result !== 16'h020E) begin
      bad++;
      $display("FAIL div_vec: got %h want 020e", result);
    end
`else
    if (result !== 16'h0000 || flags[4] !== 1'b1) begin
      bad++;
      $display("FAIL div_vec_off: got %h err %b want 0000 err 1", result, flags[4]);
    end
`endif
    load(8'd9, 8'd0);
    issue(5'b00010, 1'b0, 1'b0, '0, '0, "div_9_0");
    total++;
`ifdef ALU_DP_DIV_EN
    if (result !== 16'h09FF || flags[4] !== 1'b1) begin
      bad++;
      $display("FAIL div0_vec: got %h err %b want 09ff err 1", result, flags[4]);
    end
`else
    if (result !== 16'h0000 || flags[4] !== 1'b1) begin
      bad++;
      $display("FAIL div0_vec_off: got %h err %b want 0000 err 1", result, flags[4]);
    end
`endif
  endtask

  task automatic test_overrun();
    int cyc;
    load(8'd13, 8'd11);
    set_strb(5'b00001);
    tick();
    set_strb(5'b0);
    tick();
    tick();
    @(negedge clk);
    total++;
    if (overrun !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL ovr_pre: overrun=%b busy=%b want 0/1", overrun, busy);
    end
    aAdd = 1'b1; ldA = 1'b1; opA_in = 8'hAA;
    tick();
    aAdd = 1'b0; ldA = 1'b0;
    @(negedge clk);
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL ovr_pulse: overrun=%b want 1", overrun);
    end
    tick();
    @(negedge clk);
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL ovr_clear: overrun=%b want 0", overrun);
    end
    cyc = 5;
    while (done !== 1'b1 && cyc < 60) begin
      tick();
      cyc++;
      @(negedge clk);
    end
    total++;
    if (done !== 1'b1 || cyc != W + 1 || result !== 16'(13 * 11) || flags !== 5'b0) begin
      bad++;
      $display("FAIL ovr_mul: done=%b cyc=%0d result=%h flags=%b want 1/%0d/%h/0",
               done, cyc, result, flags, W + 1, 16'(13 * 11));
    end
    tick();
    // A must still hold 13: the busy-time ldA was dropped
    issue(5'b01000, 1'b0, 1'b0, '0, '0, "ovr_add_after");
  endtask

  task automatic test_reset_abort();
    int dones;
    load(8'd200, 8'd3);
    issue(5'b00001, 1'b0, 1'b0, '0, '0, "abort_pre_mul");
    set_strb(5'b00001);
    tick();
    set_strb(5'b0);
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    total++;
    if (result !== '0 || flags !== '0 || done !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL abort_outputs: result=%h flags=%b done=%b busy=%b ovr=%b want all 0",
               result, flags, done, busy, overrun);
    end
    reset = 1'b0;
    m_a = '0; m_b = '0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL abort_no_done: got %0d done cycles want 0", dones);
    end
    tick();
    issue(5'b10000, 1'b0, 1'b0, '0, '0, "abort_cmp_zero");
  endtask

  task automatic test_random();
    logic [4:0]   s;
    logic [W-1:0] a, b;
    logic         la, lb;
    for (int i = 0; i < 60; i++) begin
      a = W'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) load(a, b);
      s  = 5'($urandom_range(1, 31));
      la = ($urandom_range(0, 3) == 0);
      lb = ($urandom_range(0, 3) == 0);
      issue(s, la, lb, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
            $sformatf("rand%0d_s%b", i, s));
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_overrun();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
